// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ctrl_sequencer: multi-cycle P1..P5 control unit for the SIMPLE datapath (rev 1.0).
// Define CTRL_SHORT_PATH_EN to route instructions without memory access P3 -> P5.
module ctrl_sequencer #(
    parameter int INSTR_W  = 16,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_run,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [3:0]         i_alu_flags,
    input  logic               i_mem_ack,
    output logic [2:0]         o_phase,
    output logic               o_mem_req,
    output logic               o_mem_w,
    output logic               o_ir_e,
    output logic               o_alu_e,
    output logic               o_genr_w,
    output logic               o_szcv_w,
    output logic               o_jump,
    output logic               o_pc_e,
    output logic               o_out_s,
    output logic               o_m9_s,
    output logic [5:0]         o_alu_instruction,
    output logic [3:0]         o_flags,
    output logic               o_halted,
    output logic               o_timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_P1 = 3'd1, S_P2 = 3'd2, S_P3 = 3'd3, S_P4 = 3'd4, S_P5 = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_WAIT_MAX = CNT_W'(WAIT_MAX);

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_taken;
    logic               r_mem_req, r_mem_w, r_ir_e, r_alu_e, r_genr_w, r_szcv_w;
    logic               r_jump, r_pc_e, r_out_s, r_m9_s, r_halted, r_tmo;
    logic [5:0]         r_alu_instr;
    logic [3:0]         r_flags;

    state_t             w_nxt;
    logic [1:0]         w_op;
    logic [3:0]         w_fn;
    logic [2:0]         w_sub, w_cc;
    logic               w_is_ld, w_is_st, w_is_mem, w_is_alu, w_is_li, w_is_b, w_is_bc;
    logic               w_is_in, w_is_out, w_is_hlt, w_fn_wr, w_fn_flag;
    logic               w_alu_en, w_genr, w_szcv, w_shift, w_cond, w_taken;
    logic               w_ack, w_wait, w_tmo;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_unused;

    assign w_op      = r_ir[15:14];
    assign w_sub     = r_ir[13:11];
    assign w_cc      = r_ir[10:8];
    assign w_fn      = r_ir[7:4];
    assign w_unused  = ^r_ir[3:0];

    assign w_is_ld   = (w_op == 2'b00);
    assign w_is_st   = (w_op == 2'b01);
    assign w_is_mem  = w_is_ld | w_is_st;
    assign w_is_alu  = (w_op == 2'b11);
    assign w_is_li   = (w_op == 2'b10) && (w_sub == 3'b000);
    assign w_is_b    = (w_op == 2'b10) && (w_sub == 3'b100);
    assign w_is_bc   = (w_op == 2'b10) && (w_sub == 3'b111);
    assign w_is_in   = w_is_alu && (w_fn == 4'b1100);
    assign w_is_out  = w_is_alu && (w_fn == 4'b1101);
    assign w_is_hlt  = w_is_alu && (w_fn == 4'b1111);
    assign w_shift   = (w_fn[3:2] == 2'b10);
    assign w_fn_wr   = (w_fn <= 4'd4) || (w_fn == 4'd6) || w_shift;
    assign w_fn_flag = (w_fn <= 4'd6) || w_shift;

    // Undecodable op=10 encodings fall out of every class below and behave as NOP.
    assign w_alu_en  = w_is_mem | w_is_b | w_is_bc | (w_is_alu & ~w_is_in & ~w_is_out & ~w_is_hlt);
    assign w_genr    = (w_is_alu & (w_fn_wr | w_is_in)) | w_is_ld | w_is_li;
    assign w_szcv    = w_is_alu & w_fn_flag;

    // Flags are {S,Z,C,V}.
    always_comb begin
        w_cond = 1'b0;
        case (w_cc)
            3'b000:  w_cond = r_flags[2];
            3'b001:  w_cond = r_flags[3] ^ r_flags[0];
            3'b010:  w_cond = r_flags[2] | (r_flags[3] ^ r_flags[0]);
            3'b011:  w_cond = ~r_flags[2];
            default: w_cond = 1'b0;
        endcase
    end
    assign w_taken   = w_is_b | (w_is_bc & w_cond);

    // mem_req is only ever high in P1/P4, so acks elsewhere are ignored.
    assign w_ack     = r_mem_req & i_mem_ack;
    assign w_wait    = r_mem_req & ~i_mem_ack;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_tmo     = w_wait & (w_cnt_inc == c_WAIT_MAX);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: w_nxt = i_run ? S_P1 : S_IDLE;
            S_P1:   w_nxt = w_ack ? S_P2 : (w_tmo ? S_IDLE : S_P1);
            S_P2:   w_nxt = w_is_hlt ? S_IDLE : S_P3;
            S_P3: begin
`ifdef CTRL_SHORT_PATH_EN
                w_nxt = w_is_mem ? S_P4 : S_P5;
`else
                w_nxt = S_P4;
`endif
            end
            S_P4: begin
                if (!w_is_mem || w_ack) w_nxt = S_P5;
                else if (w_tmo)         w_nxt = S_IDLE;
                else                    w_nxt = S_P4;
            end
            S_P5:   w_nxt = S_P1;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_cnt       <= '0;
            r_taken     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_w     <= 1'b0;
            r_ir_e      <= 1'b0;
            r_alu_e     <= 1'b0;
            r_genr_w    <= 1'b0;
            r_szcv_w    <= 1'b0;
            r_jump      <= 1'b0;
            r_pc_e      <= 1'b0;
            r_out_s     <= 1'b0;
            r_m9_s      <= 1'b0;
            r_alu_instr <= '0;
            r_flags     <= '0;
            r_halted    <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_mem_req <= (w_nxt == S_P1) || ((w_nxt == S_P4) && w_is_mem);
            r_mem_w   <= (w_nxt == S_P4) && w_is_st;
            r_ir_e    <= (w_nxt == S_P2);
            r_alu_e   <= (w_nxt == S_P3) && w_alu_en;
            r_m9_s    <= (w_nxt == S_P3) && w_is_alu && w_shift;
            r_genr_w  <= (w_nxt == S_P5) && w_genr;
            r_szcv_w  <= (w_nxt == S_P5) && w_szcv;
            r_out_s   <= (w_nxt == S_P5) && w_is_out;
            r_pc_e    <= (w_nxt == S_P5);
            r_jump    <= (w_nxt == S_P5) && r_taken;

            // The counter restarts on every phase change, so it only accumulates within one wait.
            if (w_nxt != r_state) r_cnt <= '0;
            else if (w_wait)      r_cnt <= w_cnt_inc;

            if ((r_state == S_P1) && w_ack) begin
                r_ir        <= i_instr;
                r_alu_instr <= (i_instr[15:14] == 2'b11) ? {i_instr[15:14], i_instr[7:4]}
                                                         : i_instr[15:10];
            end
            if (r_state == S_P3)                r_taken <= w_taken;
            if ((w_nxt == S_P5) && w_szcv)      r_flags <= i_alu_flags;

            if ((r_state == S_IDLE) && i_run)                 r_halted <= 1'b0;
            else if (((r_state == S_P2) && w_is_hlt) || w_tmo) r_halted <= 1'b1;
            if (w_tmo) r_tmo <= 1'b1;
        end
    end

    assign o_phase           = r_state;
    assign o_mem_req         = r_mem_req;
    assign o_mem_w           = r_mem_w;
    assign o_ir_e            = r_ir_e;
    assign o_alu_e           = r_alu_e;
    assign o_genr_w          = r_genr_w;
    assign o_szcv_w          = r_szcv_w;
    assign o_jump            = r_jump;
    assign o_pc_e            = r_pc_e;
    assign o_out_s           = r_out_s;
    assign o_m9_s            = r_m9_s;
    assign o_alu_instruction = r_alu_instr;
    assign o_flags           = r_flags;
    assign o_halted          = r_halted;
    assign o_timeout_err     = r_tmo;
endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ctrl_sequencer: directed instruction stream; phase-change events checked against a queue.
module tb_ctrl_sequencer;
`ifdef CTRL_SHORT_PATH_EN
    localparam bit SHORT = 1'b1;
`else
    localparam bit SHORT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_run = 1'b0;
    logic [15:0] i_instr = 16'h0000;
    logic [3:0]  i_alu_flags = 4'h0;
    logic        i_mem_ack = 1'b0;
    logic [2:0]  o_phase;
    logic        o_mem_req, o_mem_w, o_ir_e, o_alu_e, o_genr_w, o_szcv_w;
    logic        o_jump, o_pc_e, o_out_s, o_m9_s, o_halted, o_timeout_err;
    logic [5:0]  o_alu_instruction;
    logic [3:0]  o_flags;

    always #5 clk = ~clk;

    ctrl_sequencer #(.INSTR_W(16), .WAIT_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_instr(i_instr),
        .i_alu_flags(i_alu_flags), .i_mem_ack(i_mem_ack), .o_phase(o_phase),
        .o_mem_req(o_mem_req), .o_mem_w(o_mem_w), .o_ir_e(o_ir_e), .o_alu_e(o_alu_e),
        .o_genr_w(o_genr_w), .o_szcv_w(o_szcv_w), .o_jump(o_jump), .o_pc_e(o_pc_e),
        .o_out_s(o_out_s), .o_m9_s(o_m9_s), .o_alu_instruction(o_alu_instruction),
        .o_flags(o_flags), .o_halted(o_halted), .o_timeout_err(o_timeout_err)
    );

    // ctl bit order: {mem_req, mem_w, ir_e, alu_e, genr_w, szcv_w, jump, pc_e, out_s, m9_s, halted, timeout_err}
    typedef struct {
        string       tag;
        int          dt;
        logic [2:0]  ph;
        logic [11:0] ctl;
        logic [3:0]  fl;
        logic [5:0]  ai;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [11:0] ctl(input logic mr, input logic mw, input logic ie, input logic ae,
                                        input logic gw, input logic sw, input logic j, input logic pe,
                                        input logic os, input logic m9, input logic h, input logic te);
        return {mr, mw, ie, ae, gw, sw, j, pe, os, m9, h, te};
    endfunction

    task automatic ev(input string tag, input int dt, input logic [2:0] ph, input logic [11:0] c,
                      input logic [3:0] fl, input logic [5:0] ai);
        exp_t e;
        e.tag = tag; e.dt = dt; e.ph = ph; e.ctl = c; e.fl = fl; e.ai = ai;
        q.push_back(e);
    endtask

    task automatic exp_instr(input string tag, input int p1_dt, input int fetch_dt,
                             input logic [5:0] ai_prev, input logic [5:0] ai,
                             input logic [3:0] fl_prev, input logic [3:0] fl_post, input logic te,
                             input logic ld, input logic st, input int p4_len,
                             input logic ae, input logic m9, input logic gw, input logic sw,
                             input logic j, input logic os);
        ev({tag, "_p1"}, p1_dt, 3'd1, ctl(1,0,0,0,0,0,0,0,0,0,0,te), fl_prev, ai_prev);
        ev({tag, "_p2"}, fetch_dt, 3'd2, ctl(0,0,1,0,0,0,0,0,0,0,0,te), fl_prev, ai);
        ev({tag, "_p3"}, 1, 3'd3, ctl(0,0,0,ae,0,0,0,0,0,m9,0,te), fl_prev, ai);
        if (ld || st || !SHORT)
            ev({tag, "_p4"}, 1, 3'd4, ctl(ld | st,st,0,0,0,0,0,0,0,0,0,te), fl_prev, ai);
        ev({tag, "_p5"}, p4_len, 3'd5, ctl(0,0,0,0,gw,sw,j,1,os,0,0,te), fl_post, ai);
    endtask

    // Monitor: every phase change is a DUT output event and consumes one expectation.
    initial begin : monitor
        exp_t        e;
        logic [11:0] act;
        logic [2:0]  prev_ph;
        int          cyc, last_evt, dt;
        prev_ph = 3'd0; cyc = 0; last_evt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (o_phase !== prev_ph) begin
                dt = cyc - last_evt;
                last_evt = cyc;
                prev_ph = o_phase;
                act = {o_mem_req, o_mem_w, o_ir_e, o_alu_e, o_genr_w, o_szcv_w,
                       o_jump, o_pc_e, o_out_s, o_m9_s, o_halted, o_timeout_err};
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got phase=%0d ctl=%b at cycle %0d, want no event",
                             o_phase, act, cyc);
                end else begin
                    e = q.pop_front();
                    if (o_phase !== e.ph || act !== e.ctl || o_flags !== e.fl ||
                        o_alu_instruction !== e.ai || (e.dt >= 0 && dt != e.dt)) begin
                        bad++;
                        $display("FAIL %s: got ph=%0d ctl=%b fl=%b ai=%b dt=%0d, want ph=%0d ctl=%b fl=%b ai=%b dt=%0d",
                                 e.tag, o_phase, act, o_flags, o_alu_instruction, dt,
                                 e.ph, e.ctl, e.fl, e.ai, e.dt);
                    end
                end
            end
        end
    end

    task automatic wait_ph(input logic [2:0] ph, input bit need_req, input string what);
        int n = 0;
        while (!(o_phase == ph && (!need_req || o_mem_req)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL wait_%s: got phase=%0d after %0d cycles, want phase=%0d", what, o_phase, n, ph);
        end
    endtask

    task automatic run_pulse();
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] ins, input int delay, input logic [3:0] fl, input bit stray);
        wait_ph(3'd1, 1'b1, "fetch");
        repeat (delay) @(negedge clk);
        i_instr = ins; i_alu_flags = fl; i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b0;
        if (stray) begin
            i_mem_ack = 1'b1;
            @(negedge clk);
            i_mem_ack = 1'b0;
        end
    endtask

    task automatic mem_p4(input int delay, input bit poke_run);
        wait_ph(3'd4, 1'b1, "p4");
        for (int k = 0; k < delay; k++) begin
            if (poke_run && k == 1) i_run = 1'b1;
            @(negedge clk);
            i_run = 1'b0;
        end
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test, want finish before 100us");
        $fatal(1);
    end

    initial begin : driver
        #12;
        total++;
        if ({o_phase, o_mem_req, o_mem_w, o_ir_e, o_alu_e, o_genr_w, o_szcv_w, o_jump, o_pc_e,
             o_out_s, o_m9_s, o_alu_instruction, o_flags, o_halted, o_timeout_err} !== 31'd0) begin
            bad++;
            $display("FAIL reset_state: got phase=%0d req=%b flags=%b halted=%b tmo=%b, want all zero",
                     o_phase, o_mem_req, o_flags, o_halted, o_timeout_err);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);

        // ADD r1,r0 with Z set by the ALU
        exp_instr("add", -1, 1, 6'b000000, 6'b110000, 4'b0000, 4'b0100, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0);
        run_pulse();
        fetch(16'hC800, 0, 4'b0100, 0);

        // LD with a 3-cycle memory wait and a run pulse that must be ignored
        exp_instr("ld", 1, 1, 6'b110000, 6'b000100, 4'b0100, 4'b0100, 0, 1, 0, 4, 1, 0, 1, 0, 0, 0);
        fetch(16'h1205, 0, 4'b0100, 0);
        mem_p4(3, 1);

        // BE with Z=1 (taken), stray ack in P2
        exp_instr("be_t", 1, 1, 6'b000100, 6'b101110, 4'b0100, 4'b0100, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        fetch(16'hB804, 0, 4'b0100, 1);

        // SLL clears the flags and selects the shift immediate
        exp_instr("sll", 1, 1, 6'b101110, 6'b111000, 4'b0100, 4'b0000, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
        fetch(16'hC080, 0, 4'b0000, 0);

        // BE with Z=0 (not taken)
        exp_instr("be_n", 1, 1, 6'b111000, 6'b101110, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        fetch(16'hB804, 0, 4'b0000, 0);

        exp_instr("out", 1, 1, 6'b101110, 6'b111101, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        fetch(16'hC0D0, 0, 4'b0000, 0);

        exp_instr("nop", 1, 1, 6'b111101, 6'b100010, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        fetch(16'h8800, 0, 4'b0000, 0);

        // HLT: idle after P2 with halted set
        ev("hlt_p1", 1, 3'd1, ctl(1,0,0,0,0,0,0,0,0,0,0,0), 4'b0000, 6'b100010);
        ev("hlt_p2", 1, 3'd2, ctl(0,0,1,0,0,0,0,0,0,0,0,0), 4'b0000, 6'b111111);
        ev("hlt_idle", 1, 3'd0, ctl(0,0,0,0,0,0,0,0,0,0,1,0), 4'b0000, 6'b111111);
        fetch(16'hC0F0, 0, 4'b0000, 0);
        wait_ph(3'd0, 1'b0, "halt");
        repeat (3) @(negedge clk);

        // Restart; fetch ack arrives in the last allowed wait cycle
        exp_instr("add_slow", -1, 15, 6'b111111, 6'b110000, 4'b0000, 4'b0100, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0);
        run_pulse();
        fetch(16'hC800, 14, 4'b0100, 0);

        // No ack at all: timeout after 15 waiting cycles
        ev("tmo_p1", 1, 3'd1, ctl(1,0,0,0,0,0,0,0,0,0,0,0), 4'b0100, 6'b110000);
        ev("tmo_idle", 15, 3'd0, ctl(0,0,0,0,0,0,0,0,0,0,1,1), 4'b0100, 6'b110000);
        wait_ph(3'd1, 1'b1, "tmo_p1");
        wait_ph(3'd0, 1'b0, "tmo_idle");
        repeat (2) @(negedge clk);

        // ST interrupted by reset in P4; timeout_err survives run but not reset
        ev("st_p1", -1, 3'd1, ctl(1,0,0,0,0,0,0,0,0,0,0,1), 4'b0100, 6'b110000);
        ev("st_p2", 1, 3'd2, ctl(0,0,1,0,0,0,0,0,0,0,0,1), 4'b0100, 6'b010010);
        ev("st_p3", 1, 3'd3, ctl(0,0,0,1,0,0,0,0,0,0,0,1), 4'b0100, 6'b010010);
        ev("st_p4", 1, 3'd4, ctl(1,1,0,0,0,0,0,0,0,0,0,1), 4'b0100, 6'b010010);
        ev("rst_idle", -1, 3'd0, ctl(0,0,0,0,0,0,0,0,0,0,0,0), 4'b0000, 6'b000000);
        run_pulse();
        fetch(16'h4A03, 0, 4'b0100, 0);
        wait_ph(3'd4, 1'b1, "st_p4");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2;
        total++;
        if (o_phase !== 3'd0 || o_mem_req !== 1'b0 || o_mem_w !== 1'b0 || o_flags !== 4'b0000 ||
            o_timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got phase=%0d req=%b w=%b flags=%b tmo=%b, want 0 0 0 0000 0",
                     o_phase, o_mem_req, o_mem_w, o_flags, o_timeout_err);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Normal operation after reset
        exp_instr("add_rst", -1, 1, 6'b000000, 6'b110000, 4'b0000, 4'b0100, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0);
        ev("end_p1", 1, 3'd1, ctl(1,0,0,0,0,0,0,0,0,0,0,0), 4'b0100, 6'b110000);
        run_pulse();
        fetch(16'hC800, 0, 4'b0100, 0);
        wait_ph(3'd1, 1'b1, "end_p1");
        repeat (2) @(negedge clk);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending events (next %s), want 0", q.size(), q[0].tag);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
